// File: rtl/rv64g_issue_window_if.sv
// Handshake bundle for the issue window: decoder-side push, execution-side
// launch, regfile lock bits, flush and occupancy.
interface rv64g_issue_window_if #(
  parameter int DEPTH = 4,
  parameter int NR    = 64,
  parameter int DW    = 128
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          clear_i;
  logic [DW-1:0] in_data_i;
  logic [NR-1:0] in_reg_req_i;
  logic          in_jump_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [NR-1:0] locks_i;
  logic [DW-1:0] out_data_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [CW-1:0] count_o;

  // Decoder / execution / regfile side.
  modport master (
    output clear_i, in_data_i, in_reg_req_i, in_jump_i, in_valid_i,
    output locks_i, out_ready_i,
    input  in_ready_o, out_data_o, out_valid_o, count_o
  );

  // The issue window itself.
  modport slave (
    input  clear_i, in_data_i, in_reg_req_i, in_jump_i, in_valid_i,
    input  locks_i, out_ready_i,
    output in_ready_o, out_data_o, out_valid_o, count_o
  );
endinterface

// File: rtl/rv64g_issue_window.sv
// Age-ordered compacting issue window. Slot 0 is the oldest entry; the oldest
// hazard-free entry launches each cycle and younger entries shift down.
module rv64g_issue_window #(
  parameter int DEPTH    = 4,
  parameter int NR       = 64,
  parameter int DW       = 128,
  parameter bit IN_ORDER = 1'b0
) (
  input logic clk_i,
  input logic arst_i,
  rv64g_issue_window_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  // Register x0 never creates a hazard.
  localparam logic [NR-1:0] X0_MASK = ~(NR'(1));

  logic [DEPTH-1:0] valid_q, valid_d, elig;
  logic [DEPTH-1:0] jump_q, jump_d;
  logic [DW-1:0]    data_q [DEPTH];
  logic [DW-1:0]    data_d [DEPTH];
  logic [NR-1:0]    req_q  [DEPTH];
  logic [NR-1:0]    req_d  [DEPTH];
  logic [CW-1:0]    count_q, count_d, sel, wr_idx;
  logic [NR-1:0]    locks_m, older_req;
  logic [DW-1:0]    out_data;
  logic             older_jump, any_elig, in_ready, out_valid, launch, accept;

  assign locks_m = bus.locks_i & X0_MASK;

  // Per-slot eligibility against locks, older register usage and jump barrier.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update so no latch is inferred.
    older_req  = '0;
    older_jump = 1'b0;
    elig       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      elig[i] = valid_q[i]
             && ((req_q[i] & locks_m) == '0)
             && ((req_q[i] & older_req) == '0)
             && !older_jump
             && (!jump_q[i] || i == 0)
             && (!IN_ORDER || i == 0);
      if (valid_q[i]) begin
        older_req  = older_req | req_q[i];
        older_jump = older_jump | jump_q[i];
      end
    end
  end

  // Pick the lowest-index eligible slot.
  always_comb begin
    any_elig = 1'b0;
    sel      = '0;
    out_data = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        any_elig = 1'b1;
        sel      = CW'(i);
        out_data = data_q[i];
      end
    end
  end

  // in_ready depends only on registered count and clear, never on out_ready.
  assign in_ready  = (count_q < CW'(DEPTH)) && !bus.clear_i;
  assign out_valid = any_elig && !bus.clear_i;
  assign launch    = out_valid && bus.out_ready_i;
  assign accept    = bus.in_valid_i && in_ready;
  // A same-cycle launch compacts the queue, so the new entry lands one lower.
  assign wr_idx    = launch ? count_q - CW'(1) : count_q;

  // Next slot contents: shift younger entries over the launched one, then write.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      int nx;
      nx        = (i < DEPTH - 1) ? i + 1 : i;
      valid_d[i] = valid_q[i];
      data_d[i]  = data_q[i];
      req_d[i]   = req_q[i];
      jump_d[i]  = jump_q[i];
      if (launch && CW'(i) >= sel) begin
        valid_d[i] = (i < DEPTH - 1) ? valid_q[nx] : 1'b0;
        data_d[i]  = data_q[nx];
        req_d[i]   = req_q[nx];
        jump_d[i]  = jump_q[nx];
      end
      if (accept && CW'(i) == wr_idx) begin
        valid_d[i] = 1'b1;
        data_d[i]  = bus.in_data_i;
        req_d[i]   = bus.in_reg_req_i & X0_MASK;
        jump_d[i]  = bus.in_jump_i;
      end
    end
    unique case ({accept, launch})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Occupancy state: async reset, synchronous flush.
  always_ff @(posedge clk_i or posedge arst_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (arst_i) begin
      valid_q <= '0;
      count_q <= '0;
    end else if (bus.clear_i) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Payload storage, qualified everywhere by the valid bits.
  always_ff @(posedge clk_i) begin
    // NOTE: payload arrays carry no reset; an invalid slot's contents are never observed.
    for (int i = 0; i < DEPTH; i++) begin
      data_q[i] <= data_d[i];
      req_q[i]  <= req_d[i];
      jump_q[i] <= jump_d[i];
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.out_data_o  = out_data;
  assign bus.count_o     = count_q;
endmodule

// File: tb/tb_rv64g_issue_window.sv
// Directed bench for the issue window with a launch-order scoreboard.
module tb_rv64g_issue_window;
  localparam int DEPTH = 4;
  localparam int NR    = 64;
  localparam int DW    = 128;

  logic clk_i = 1'b0;
  logic arst_i = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [DW-1:0] sb [$];

  always #5 clk_i = ~clk_i;

  rv64g_issue_window_if #(.DEPTH(DEPTH), .NR(NR), .DW(DW)) b0 ();
  rv64g_issue_window_if #(.DEPTH(DEPTH), .NR(NR), .DW(DW)) b1 ();

  rv64g_issue_window #(.DEPTH(DEPTH), .NR(NR), .DW(DW), .IN_ORDER(1'b0)) u0 (
    .clk_i(clk_i), .arst_i(arst_i), .bus(b0)
  );
  rv64g_issue_window #(.DEPTH(DEPTH), .NR(NR), .DW(DW), .IN_ORDER(1'b1)) u1 (
    .clk_i(clk_i), .arst_i(arst_i), .bus(b1)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [127:0] d, input logic [63:0] req, input logic jmp);
    b0.in_data_i    = d;
    b0.in_reg_req_i = req;
    b0.in_jump_i    = jmp;
    b0.in_valid_i   = 1'b1;
    cyc();
    b0.in_valid_i   = 1'b0;
  endtask

  task automatic push1(input logic [127:0] d, input logic [63:0] req);
    b1.in_data_i    = d;
    b1.in_reg_req_i = req;
    b1.in_jump_i    = 1'b0;
    b1.in_valid_i   = 1'b1;
    cyc();
    b1.in_valid_i   = 1'b0;
  endtask

  // Scoreboard: every handshake on the out-of-order window pops the next expected payload.
  always @(negedge clk_i) begin
    if (!arst_i && b0.out_valid_o && b0.out_ready_i) begin
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_launch observed=%0h expected=none", b0.out_data_o);
      end
      if (sb.size() != 0) chk("launch_data", b0.out_data_o, sb.pop_front());
    end
  end

  initial begin
    b0.clear_i = 0; b0.in_data_i = '0; b0.in_reg_req_i = '0; b0.in_jump_i = 0;
    b0.in_valid_i = 0; b0.locks_i = '0; b0.out_ready_i = 0;
    b1.clear_i = 0; b1.in_data_i = '0; b1.in_reg_req_i = '0; b1.in_jump_i = 0;
    b1.in_valid_i = 0; b1.locks_i = '0; b1.out_ready_i = 0;

    // Reset then idle.
    #12 arst_i = 1'b0;
    #1;
    chk("rst_count", b0.count_o, 0);
    chk("rst_out_valid", b0.out_valid_o, 0);
    chk("rst_in_ready", b0.in_ready_o, 1);
    chk("rst_out_data", b0.out_data_o, 0);

    // Single push launches the following cycle.
    cyc();
    b0.out_ready_i = 1'b1;
    b0.in_data_i = 128'hA1; b0.in_reg_req_i = 64'h6; b0.in_jump_i = 0; b0.in_valid_i = 1;
    #1;
    chk("accept_cycle_no_launch", b0.out_valid_o, 0);
    chk("accept_cycle_in_ready", b0.in_ready_o, 1);
    cyc();
    b0.in_valid_i = 0;
    sb.push_back(128'hA1);
    chk("single_count1", b0.count_o, 1);
    chk("single_out_data", b0.out_data_o, 128'hA1);
    cyc();
    chk("single_count0", b0.count_o, 0);

    // Fill with disjoint masks while blocked downstream.
    b0.out_ready_i = 0;
    push(128'hD0, 64'h02, 0);
    push(128'hD1, 64'h04, 0);
    push(128'hD2, 64'h08, 0);
    push(128'hD3, 64'h10, 0);
    chk("full_count", b0.count_o, 4);
    chk("full_in_ready", b0.in_ready_o, 0);
    b0.in_data_i = 128'hD4; b0.in_reg_req_i = 64'h20; b0.in_valid_i = 1;
    cyc();
    cyc();
    chk("full_no_fifth", b0.count_o, 4);
    sb.push_back(128'hD0); sb.push_back(128'hD1); sb.push_back(128'hD2); sb.push_back(128'hD3);
    b0.out_ready_i = 1;
    #1;
    chk("full_ready_during_launch", b0.in_ready_o, 0);
    cyc();
    b0.in_valid_i = 0;
    cyc(); cyc(); cyc();
    chk("drain_count", b0.count_o, 0);
    chk("drain_sb_empty", sb.size(), 0);

    // Out-of-order: locked A is bypassed by independent B.
    b0.out_ready_i = 0; b0.locks_i = 64'h2;
    push(128'hA3, 64'h2, 0);
    push(128'hB3, 64'h4, 0);
    sb.push_back(128'hB3); sb.push_back(128'hA3);
    b0.out_ready_i = 1;
    #1;
    chk("ooo_out_valid", b0.out_valid_o, 1);
    chk("ooo_out_data", b0.out_data_o, 128'hB3);
    cyc();
    chk("ooo_count", b0.count_o, 1);
    chk("ooo_a_locked", b0.out_valid_o, 0);
    b0.locks_i = 0;
    #1;
    chk("ooo_a_unlocked", b0.out_data_o, 128'hA3);
    cyc();
    chk("ooo_count0", b0.count_o, 0);

    // Older-conflict block: B overlaps locked A.
    b0.out_ready_i = 0; b0.locks_i = 64'h2;
    push(128'hA4, 64'h6, 0);
    push(128'hB4, 64'h4, 0);
    b0.out_ready_i = 1;
    #1;
    chk("conflict_no_launch", b0.out_valid_o, 0);
    cyc();
    chk("conflict_count", b0.count_o, 2);
    sb.push_back(128'hA4); sb.push_back(128'hB4);
    b0.locks_i = 0;
    cyc(); cyc();
    chk("conflict_count0", b0.count_o, 0);

    // Strict in-order window: disjoint B still waits behind locked A.
    b1.locks_i = 64'h2; b1.out_ready_i = 1;
    push1(128'hA5, 64'h2);
    push1(128'hB5, 64'h4);
    chk("inorder_blocked", b1.out_valid_o, 0);
    chk("inorder_count", b1.count_o, 2);
    b1.locks_i = 0;
    #1;
    chk("inorder_a_first", b1.out_data_o, 128'hA5);
    cyc();
    chk("inorder_b_next", b1.out_data_o, 128'hB5);

    // Jump barrier: J and younger wait behind locked A.
    b0.out_ready_i = 0; b0.locks_i = 64'h2;
    push(128'hA6, 64'h02, 0);
    push(128'hF6, 64'h08, 1);
    push(128'hC6, 64'h10, 0);
    b0.out_ready_i = 1;
    #1;
    chk("jump_barrier", b0.out_valid_o, 0);
    cyc();
    chk("jump_count", b0.count_o, 3);
    sb.push_back(128'hA6); sb.push_back(128'hF6); sb.push_back(128'hC6);
    b0.locks_i = 0;
    cyc();
    chk("jump_next", b0.out_data_o, 128'hF6);
    cyc(); cyc();
    chk("jump_count0", b0.count_o, 0);

    // Simultaneous accept and launch at count 2.
    b0.out_ready_i = 0; b0.locks_i = 64'h2;
    push(128'hA7, 64'h2, 0);
    push(128'hB7, 64'h4, 0);
    sb.push_back(128'hB7); sb.push_back(128'hC7); sb.push_back(128'hA7);
    b0.in_data_i = 128'hC7; b0.in_reg_req_i = 64'h8; b0.in_jump_i = 0; b0.in_valid_i = 1;
    b0.out_ready_i = 1;
    #1;
    chk("simul_in_ready", b0.in_ready_o, 1);
    chk("simul_launch_b", b0.out_data_o, 128'hB7);
    cyc();
    b0.in_valid_i = 0;
    chk("simul_count", b0.count_o, 2);
    chk("simul_slot1_c", b0.out_data_o, 128'hC7);
    cyc();
    b0.locks_i = 0;
    cyc();
    chk("simul_count0", b0.count_o, 0);

    // Flush with three entries.
    b0.out_ready_i = 0;
    push(128'hD8, 64'h02, 0);
    push(128'hE8, 64'h04, 0);
    push(128'hF8, 64'h08, 0);
    chk("clear_pre_count", b0.count_o, 3);
    b0.clear_i = 1; b0.out_ready_i = 1;
    b0.in_data_i = 128'h98; b0.in_reg_req_i = 64'h10; b0.in_valid_i = 1;
    #1;
    chk("clear_out_valid", b0.out_valid_o, 0);
    chk("clear_in_ready", b0.in_ready_o, 0);
    cyc();
    b0.clear_i = 0; b0.in_valid_i = 0;
    chk("clear_count", b0.count_o, 0);
    chk("clear_empty", b0.out_valid_o, 0);

    // x0 is ignored in both locks and requests.
    b0.locks_i = 64'h1;
    push(128'hAA, 64'h1, 0);
    sb.push_back(128'hAA);
    chk("x0_ignored", b0.out_valid_o, 1);
    cyc();
    chk("x0_count0", b0.count_o, 0);

    // Asynchronous reset mid-operation.
    b0.out_ready_i = 0; b0.locks_i = 0;
    push(128'hBB, 64'h4, 0);
    chk("pre_arst_count", b0.count_o, 1);
    #2 arst_i = 1;
    #1;
    chk("arst_count", b0.count_o, 0);
    chk("arst_out_valid", b0.out_valid_o, 0);
    #1 arst_i = 0;
    cyc();
    chk("final_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
